// File: rtl/bss_pkg.sv
// -----------------------------------------------------------------------------
// bss_pkg
// Shared definitions for the byte-serial subtractor slice of the codebase.
//   state_e            : controller states (IDLE, RUN, DONE)
//   DEF_WIDTH/SLICE    : default operand width and bits processed per cycle
//   OP_SUB / OP_ADD    : operation encoding, used only when BSS_ADD_MODE_EN
//                        is defined (adds the op port)
// -----------------------------------------------------------------------------
package bss_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLICE = 8;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

endpackage

// File: rtl/byte_serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// byte_serial_subtractor_if
// Request/result handshake bundle for byte_serial_subtractor.
//   Request : in_valid, in_ready, a, b, bin (+ op when BSS_ADD_MODE_EN)
//   Result  : out_valid, out_ready, diff, bout, ovf
// Modports:
//   master : requester/consumer side (drives request, out_ready)
//   slave  : the subtractor itself
// Optional macro: BSS_ADD_MODE_EN adds the 1-bit op signal.
// -----------------------------------------------------------------------------
interface byte_serial_subtractor_if
  import bss_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
`ifdef BSS_ADD_MODE_EN
  logic             op;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin,
`ifdef BSS_ADD_MODE_EN
    output op,
`endif
    output out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin,
`ifdef BSS_ADD_MODE_EN
    input  op,
`endif
    input  out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );

endinterface

// File: rtl/sub_slice.sv
// -----------------------------------------------------------------------------
// sub_slice
// Combinational SLICE-bit subtract: {bout, d} = a - b - bin.
// Ports:
//   a, b  in  SLICE  operand slices
//   bin   in  1      borrow-in (carry-in in add mode)
//   op    in  1      only with BSS_ADD_MODE_EN; OP_ADD gives a + b + bin
//   d     out SLICE  result slice
//   bout  out 1      borrow-out (carry-out in add mode)
// -----------------------------------------------------------------------------
module sub_slice
  import bss_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
`ifdef BSS_ADD_MODE_EN
  input  logic             op,
`endif
  output logic [SLICE-1:0] d,
  output logic             bout
);

  // One extra bit: for subtraction a negative result wraps so that the top
  // bit is set, which is exactly the borrow-out.
  logic [SLICE:0] res;

  always_comb begin
    res = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};
`ifdef BSS_ADD_MODE_EN
    if (op == OP_ADD) begin
      res = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, bin};
    end
`endif
  end

  assign d    = res[SLICE-1:0];
  assign bout = res[SLICE];

endmodule

// File: rtl/byte_serial_subtractor.sv
// -----------------------------------------------------------------------------
// byte_serial_subtractor
// Multi-cycle D = A - B - bin over WIDTH bits, one SLICE-bit slice per clock,
// least-significant slice first, borrow rippling through a register.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset
//   bus  slave modport of byte_serial_subtractor_if
//        (in_valid/in_ready/a/b/bin request, out_valid/out_ready/diff/bout/ovf
//        result)
// Optional macro: BSS_ADD_MODE_EN adds bus.op; op=OP_ADD computes A + B + bin,
// bout becomes carry-out and ovf uses the addition overflow rule.
// Latency: accept at edge N -> out_valid after edge N+NSLICE.
// -----------------------------------------------------------------------------
module byte_serial_subtractor
  import bss_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic                     clk,
  input  logic                     rst,
  byte_serial_subtractor_if.slave  bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_RUN  = S_RUN;
  localparam logic [1:0] ST_DONE = S_DONE;

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             borrow_reg;
  logic             bout_reg;
  logic             ovf_reg;
  logic             out_valid_reg;
`ifdef BSS_ADD_MODE_EN
  logic             op_reg;
`endif

  logic [SLICE-1:0] a_sl [NSLICE];
  logic [SLICE-1:0] b_sl [NSLICE];
  logic [WIDTH-1:0] diff_w;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_d;
  logic             slice_bout;
  logic             last_slice;
  logic             ovf_calc;

  // Split latched operands into slices; each diff slice is its own register,
  // written only on the RUN cycle whose counter selects it.
  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      logic [SLICE-1:0] d_reg;

      assign a_sl[gi] = a_reg[gi*SLICE +: SLICE];
      assign b_sl[gi] = b_reg[gi*SLICE +: SLICE];
      assign diff_w[gi*SLICE +: SLICE] = d_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          d_reg <= '0;
        end else if (state_reg == ST_RUN && cnt_reg == CNT_W'(gi)) begin
          d_reg <= slice_d;
        end
      end
    end
  endgenerate

  assign slice_a    = a_sl[cnt_reg];
  assign slice_b    = b_sl[cnt_reg];
  assign last_slice = (cnt_reg == CNT_W'(NSLICE - 1));

  sub_slice #(
    .SLICE (SLICE)
  ) u_sub_slice (
    .a    (slice_a),
    .b    (slice_b),
    .bin  (borrow_reg),
`ifdef BSS_ADD_MODE_EN
    .op   (op_reg),
`endif
    .d    (slice_d),
    .bout (slice_bout)
  );

  // Signed overflow, evaluated on the last slice where slice_d carries the
  // result MSB before it is registered.
  always_comb begin
    ovf_calc = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
               (slice_d[SLICE-1] != a_reg[WIDTH-1]);
`ifdef BSS_ADD_MODE_EN
    if (op_reg == OP_ADD) begin
      ovf_calc = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                 (slice_d[SLICE-1] != a_reg[WIDTH-1]);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      borrow_reg    <= 1'b0;
      bout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
`ifdef BSS_ADD_MODE_EN
      op_reg        <= OP_SUB;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_reg      <= bus.a;
            b_reg      <= bus.b;
            borrow_reg <= bus.bin;
`ifdef BSS_ADD_MODE_EN
            op_reg     <= bus.op;
`endif
            cnt_reg    <= '0;
            state_reg  <= ST_RUN;
          end
        end
        ST_RUN: begin
          borrow_reg <= slice_bout;
          cnt_reg    <= cnt_reg + 1'b1;
          if (last_slice) begin
            bout_reg      <= slice_bout;
            ovf_reg       <= ovf_calc;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == ST_IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.diff      = diff_w;
  assign bus.bout      = bout_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: doc/byte_serial_subtractor.md
Name: byte_serial_subtractor

Overview:
- Multi-cycle wide subtractor, the inverse operation of the team's 64-bit adder family.
- Computes D = A - B - bin over WIDTH bits, processing one SLICE-bit slice per clock, least-significant slice first, with the borrow rippling through a register.
- Sits behind a valid/ready request interface and in front of a valid/ready result interface, so datapaths can trade area for latency against the combinational adders.

Parameters:
- WIDTH, 64, operand and result width in bits; must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle.
- NSLICE, WIDTH/SLICE, derived number of slices (localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- diff  out  WIDTH  A - B - bin, modulo 2^WIDTH.
- bout  out  1  final borrow-out; 1 when the unsigned result is negative.
- ovf  out  1  signed overflow: sign(a) != sign(b) and sign(diff) != sign(a).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state is updated on the rising edge.
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, slice counter=0, borrow register=0.
- FSM states:
  - IDLE:
    - in_ready=1.
    - When in_valid & in_ready: latch a, b and bin into operand registers, clear the slice counter, and go to RUN.
  - RUN:
    - in_ready=0.
    - Each cycle, subtract slice k (counter k) of a and b using the borrow register, write diff slice k, update the borrow register, and increment k.
    - After slice NSLICE-1: set bout to the final borrow, compute ovf from the latched operand MSBs and the diff MSB, assert out_valid, and go to DONE.
  - DONE:
    - out_valid=1; diff, bout and ovf held stable.
    - When out_valid & out_ready: clear out_valid and go to IDLE.
- Latency: an accept at edge N gives out_valid high after edge N+NSLICE (8 cycles at defaults).
- Throughput: one result per NSLICE+2 cycles. No accept in the cycle the result leaves, because in_ready rises the cycle after the DONE->IDLE transition.
- diff is written in place slice by slice. Its contents are undefined to the consumer while out_valid=0.
- Operands are captured at accept; later changes on a, b or bin have no effect.
- in_valid while busy is ignored. The requester must hold it until accepted.
- out_ready held low keeps DONE and the result indefinitely (backpressure).
- rst asserted in any state, including mid-RUN, aborts the operation and applies the reset values at that edge. No partial result is ever flagged valid.
- Wrap-around examples: 0 - 1 gives diff=all-ones, bout=1. With NSLICE=1 the block still spends one RUN cycle.

Optional Feature:
- Macro: BSS_ADD_MODE_EN.
- Defined:
  - Adds input port op (1 bit), latched at accept.
  - op=1 computes A + B + bin. bout then carries the carry-out, and ovf uses the addition rule (equal operand signs, differing result sign).
  - op=0 computes subtraction exactly as above.
- Undefined: no op port; subtraction only.

Decomposition:
- Package bss_pkg holds:
  - state enum type (IDLE, RUN, DONE);
  - default WIDTH and SLICE constants;
  - op encoding constants OP_SUB=0, OP_ADD=1.
- One combinational sub-module, sub_slice (SLICE-bit a - b - borrow, giving diff and borrow-out; add-mode variant under the macro). It is instantiated once and indexed by the slice counter.

Test Plan:
- After reset: in_ready=1, out_valid=0, diff=0. Then a=100, b=58, bin=0 gives diff=42, bout=0, ovf=0 exactly 8 cycles after accept.
- a=0, b=1, bin=0 gives diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0. Then a=0x8000_0000_0000_0000, b=1 gives diff=0x7FFF_FFFF_FFFF_FFFF, ovf=1, bout=0.
- a=0x0100, b=0x00FF, bin=1 (borrow crossing a slice boundary) gives diff=0; a=0x0000_0001_0000_0000, b=1 gives diff=0x0000_0000_FFFF_FFFF.
- Hold out_ready=0 for 20 cycles: out_valid stays 1, diff stable, in_ready=0, a second in_valid ignored. Release: result consumed, in_ready=1 next cycle.
- Pulse rst at RUN cycle 4: next cycle state IDLE, out_valid=0, diff=0. A fresh request then completes with the correct result.
- With BSS_ADD_MODE_EN: op=1, a=0xFFFF_FFFF_FFFF_FFFF, b=1, bin=0 gives diff=0, bout=1. op=1, a=0x7FFF_FFFF_FFFF_FFFF, b=1 gives ovf=1.
